ex_issue_sched: RTL
===================

// Module: ex_issue_sched
// PURPOSE
//  In-order dual-lane issue scheduler in front of the dual-ALU execute stage.
//  Buffers decoded ops in a DEPTH-entry circular queue and issues the oldest
//  one or two per cycle to lanes 0/1. Holds lane 1 on a shared-memory-port or
//  same-rd hazard. Lane outputs drive the execute stage's issue/valid inputs.
//  The execute stage's per-lane ALU ready comes back as io_lane_ready_in_N.
// PARAMETERS
//  DEPTH  4   queue entries; power of 2, >=2
//  XLEN   32  operand/immediate width
// PORTS
//  clock                  in   1     sole clock, all state on rising edge
//  reset                  in   1     synchronous, active-high
//  io_flush               in   1     drop all queued ops (sync)
//  io_enq_valid           in   1     decode offers an op
//  io_enq_ready           out  1     queue can accept
//  io_enq_bits_rs1/rs2    in   XLEN  operand values
//  io_enq_bits_imm        in   XLEN  immediate
//  io_enq_bits_op         in   4     ALU opcode
//  io_enq_bits_isMem      in   1     memory op
//  io_enq_bits_memOp      in   2     memory sub-op
//  io_enq_bits_rd         in   5     destination register
//  io_enq_bits_rdWen      in   1     writes rd
//  io_issue_out_N_*       out  -     N=0,1; same fields/widths as enq_bits
//  io_valid_out_N         out  1     lane N carries a valid op
//  io_lane_ready_in_N     in   1     lane N ALU can accept
//  io_count               out  log2(DEPTH)+1  occupied entries
//  io_dual_cnt            out  32    cycles with both lanes fired
// BEHAVIOUR
//  - State: entry array, head, tail (log2(DEPTH) bits, wrap mod DEPTH),
//    count (0..DEPTH), dual_cnt.
//  - Reset: head=tail=count=0, dual_cnt=0. While reset is high,
//    io_valid_out_0/1=0 and io_enq_ready=0. Entry payloads are not reset.
//  - io_enq_ready = (count<DEPTH) & !io_flush. Enqueue when valid&ready:
//    write at tail, tail+1. Uses registered count; no bypass, so the slot
//    freed by a same-cycle dequeue is not usable that cycle.
//  - Lane 0 op = entry[head]. valid_out_0 = (count>=1) & !io_flush.
//  - Lane 1 op = entry[head+1]. Hazard = (both isMem) |
//    (both rdWen & rd equal & rd!=0).
//    valid_out_1 = (count>=2) & !hazard & io_lane_ready_in_0 & !io_flush.
//  - fire_N = valid_out_N & lane_ready_in_N. Lane 1 never fires unless lane 0
//    fires, so issue stays in program order.
//  - deq = fire_0 + fire_1. head += deq (mod DEPTH).
//    count += enq - deq, applied in the same cycle.
//  - Latency: an op enqueued in cycle t is issued no earlier than t+1.
//    Issue outputs come combinationally from queue registers.
//  - Payload outputs show entry contents whatever valid is; consumers must
//    qualify them with valid.
//  - io_flush: that cycle, no enq, no fire. Next cycle head=tail=count=0.
//    dual_cnt is kept.
//  - io_flush together with reset: reset wins; result is identical.
//  - dual_cnt += 1 when fire_0 & fire_1; wraps 0xFFFF_FFFF -> 0.
//  - Full (count=DEPTH) with a same-cycle enq attempt: enq_ready=0, op held
//    upstream.
//  - Empty: both valid_out=0.
//  - Lane ready dropping mid-stream: entries stay queued, no loss or dup.
// TESTING
//  - Reset, enq 4 ALU ops (rd 1..4), both lanes ready -> pairs (1,2) then
//    (3,4) on consecutive cycles; dual_cnt=2; count ends 0.
//  - Two isMem ops queued, both ready -> cycle1 lane0 only, cycle2 lane0
//    only; valid_out_1=0 throughout.
//  - Ops rd=5 rdWen=1 twice -> issue split across 2 cycles. Same with rd=0
//    -> dual issue.
//  - lane_ready_in_0=0, lane_ready_in_1=1, count=2 -> valid_out_1=0,
//    nothing fires, count stays 2.
//  - Fill to DEPTH=4, enq_valid held -> enq_ready=0. One lane-0 fire ->
//    enq_ready=1 the following cycle; tail wraps to 0 correctly.
//  - count=3, flush with enq_valid=1 -> no fire that cycle; next cycle
//    count=0, valids 0. Reset mid-queue -> same, and dual_cnt=0.

Source files
------------

// File: rtl/ex_issue_sched.sv
// ex_issue_sched: in-order dual-lane issue scheduler feeding the dual-ALU
// execute stage. Decoded ops are buffered in a DEPTH-entry circular queue;
// each cycle the oldest op goes to lane 0 and, when no hazard blocks it, the
// next-oldest goes to lane 1.
//
// Ports:
//   clock, reset               sole clock; synchronous active-high reset
//   io_flush                   drop every queued op (takes effect next cycle)
//   io_enq_valid/ready         decode handshake
//   io_enq_bits_*              op payload (rs1, rs2, imm, op, isMem, memOp, rd, rdWen)
//   io_issue_out_{0,1}_*       lane payloads, combinational from queue entries
//   io_valid_out_{0,1}         lane carries a valid op
//   io_lane_ready_in_{0,1}     lane ALU can accept
//   io_count                   occupied entries
//   io_dual_cnt                cycles in which both lanes fired
module ex_issue_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_flush,
  input  logic                     io_enq_valid,
  output logic                     io_enq_ready,
  input  logic [XLEN-1:0]          io_enq_bits_rs1,
  input  logic [XLEN-1:0]          io_enq_bits_rs2,
  input  logic [XLEN-1:0]          io_enq_bits_imm,
  input  logic [3:0]               io_enq_bits_op,
  input  logic                     io_enq_bits_isMem,
  input  logic [1:0]               io_enq_bits_memOp,
  input  logic [4:0]               io_enq_bits_rd,
  input  logic                     io_enq_bits_rdWen,
  output logic [XLEN-1:0]          io_issue_out_0_rs1,
  output logic [XLEN-1:0]          io_issue_out_0_rs2,
  output logic [XLEN-1:0]          io_issue_out_0_imm,
  output logic [3:0]               io_issue_out_0_op,
  output logic                     io_issue_out_0_isMem,
  output logic [1:0]               io_issue_out_0_memOp,
  output logic [4:0]               io_issue_out_0_rd,
  output logic                     io_issue_out_0_rdWen,
  output logic [XLEN-1:0]          io_issue_out_1_rs1,
  output logic [XLEN-1:0]          io_issue_out_1_rs2,
  output logic [XLEN-1:0]          io_issue_out_1_imm,
  output logic [3:0]               io_issue_out_1_op,
  output logic                     io_issue_out_1_isMem,
  output logic [1:0]               io_issue_out_1_memOp,
  output logic [4:0]               io_issue_out_1_rd,
  output logic                     io_issue_out_1_rdWen,
  output logic                     io_valid_out_0,
  output logic                     io_valid_out_1,
  input  logic                     io_lane_ready_in_0,
  input  logic                     io_lane_ready_in_1,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic [31:0]              io_dual_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      op;
    logic            is_mem;
    logic [1:0]      mem_op;
    logic [4:0]      rd;
    logic            rd_wen;
  } entry_t;

  entry_t        entries_q [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [31:0]   dual_cnt_q;

  entry_t        enq_entry;
  entry_t        lane0;
  entry_t        lane1;
  logic [AW-1:0] head_nxt1;
  logic          hazard;
  logic          enq_fire;
  logic          fire0;
  logic          fire1;
  logic [1:0]    deq;

  assign enq_entry = '{rs1: io_enq_bits_rs1, rs2: io_enq_bits_rs2,
                       imm: io_enq_bits_imm, op: io_enq_bits_op,
                       is_mem: io_enq_bits_isMem, mem_op: io_enq_bits_memOp,
                       rd: io_enq_bits_rd, rd_wen: io_enq_bits_rdWen};

  // Oldest two entries are presented to the lanes regardless of validity.
  assign head_nxt1 = head_q + AW'(1);
  assign lane0     = entries_q[head_q];
  assign lane1     = entries_q[head_nxt1];

  // Lane 1 must not share the memory port or race lane 0 on the same rd.
  assign hazard = (lane0.is_mem & lane1.is_mem) |
                  (lane0.rd_wen & lane1.rd_wen & (lane0.rd == lane1.rd) &
                   (lane0.rd != 5'd0));

  // Handshakes use the registered count only; a slot freed this cycle is not reusable yet.
  assign io_enq_ready   = !reset && !io_flush && (count_q < CW'(DEPTH));
  assign io_valid_out_0 = !reset && !io_flush && (count_q >= CW'(1));
  // Requiring lane 0 ready keeps lane 1 from ever firing ahead of lane 0.
  assign io_valid_out_1 = !reset && !io_flush && (count_q >= CW'(2)) &&
                          !hazard && io_lane_ready_in_0;

  assign enq_fire = io_enq_valid & io_enq_ready;
  assign fire0    = io_valid_out_0 & io_lane_ready_in_0;
  assign fire1    = io_valid_out_1 & io_lane_ready_in_1;
  assign deq      = {1'b0, fire0} + {1'b0, fire1};

  // Queue pointers, occupancy and dual-issue statistic.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      dual_cnt_q <= '0;
    end else if (io_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) begin
        tail_q <= tail_q + AW'(1);
      end
      head_q  <= head_q + AW'(deq);
      count_q <= count_q + CW'(enq_fire) - CW'(deq);
      if (fire0 && fire1) begin
        dual_cnt_q <= dual_cnt_q + 32'd1;
      end
    end
  end

  // Entry payload storage; contents are never reset.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      entries_q[tail_q] <= enq_entry;
    end
  end

  assign io_issue_out_0_rs1   = lane0.rs1;
  assign io_issue_out_0_rs2   = lane0.rs2;
  assign io_issue_out_0_imm   = lane0.imm;
  assign io_issue_out_0_op    = lane0.op;
  assign io_issue_out_0_isMem = lane0.is_mem;
  assign io_issue_out_0_memOp = lane0.mem_op;
  assign io_issue_out_0_rd    = lane0.rd;
  assign io_issue_out_0_rdWen = lane0.rd_wen;
  assign io_issue_out_1_rs1   = lane1.rs1;
  assign io_issue_out_1_rs2   = lane1.rs2;
  assign io_issue_out_1_imm   = lane1.imm;
  assign io_issue_out_1_op    = lane1.op;
  assign io_issue_out_1_isMem = lane1.is_mem;
  assign io_issue_out_1_memOp = lane1.mem_op;
  assign io_issue_out_1_rd    = lane1.rd;
  assign io_issue_out_1_rdWen = lane1.rd_wen;
  assign io_count             = count_q;
  assign io_dual_cnt          = dual_cnt_q;

endmodule
